// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame layout and line levels.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

    typedef enum logic {IDLE, SEND} uart_tx_state_t;

    // Frame as it sits in the shift register: start bit in the LSB goes out first.
    typedef struct packed {
        logic                 stop;
        logic [DATA_BITS-1:0] data;
        logic                 start;
    } uart_frame_t;

endpackage

// File: rtl/uart_if.sv
// Host byte interface and serial line of the UART transmitter.
interface uart_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 TxD;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, TxD, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, TxD, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..div_sample-1, flags the last and second-to-last clock of each bit.
module uart_baud_tick #(
    parameter int unsigned div_sample = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick_c,
    output logic pre_tick_c
);
    localparam int unsigned cnt_w = (div_sample > 2) ? $clog2(div_sample) : 1;

    if (div_sample < 2) begin : g_div_check
        $error("uart_baud_tick: div_sample must be at least 2");
    end

    logic [cnt_w-1:0] cnt_q;
    logic [cnt_w-1:0] cnt_d;

    assign tick_c     = (cnt_q == cnt_w'(div_sample - 1));
    assign pre_tick_c = (cnt_q == cnt_w'(div_sample - 2));

    always_comb begin
        cnt_d = cnt_q + cnt_w'(1);
        if (clear || tick_c) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-entry holding register for back-to-back frames.
module uart_transmitter #(
    parameter int unsigned clk_freq  = 50_000_000,
    parameter int unsigned baud_rate = 1_000_000
) (
    input  logic   clk,
    input  logic   reset,
    uart_if.slave  bus
);
    import uart_pkg::*;

    localparam int unsigned div_sample = clk_freq / baud_rate;
    localparam logic [3:0]  last_bit   = 4'(FRAME_BITS - 1);

    uart_tx_state_t        state_q, state_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0]  hold_reg_q, hold_reg_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  tx_done_q, tx_done_d;
    logic                  bit_end_c, pre_end_c, cnt_clear_c;
    uart_frame_t           frame_c;

    assign cnt_clear_c = (state_q == IDLE);

    uart_baud_tick #(.div_sample(div_sample)) u_baud_tick (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear_c),
        .tick_c     (bit_end_c),
        .pre_tick_c (pre_end_c)
    );

    // Next-state logic: host accept, frame load, bit shifting and done look-ahead.
    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_reg_d  = hold_reg_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        tx_done_d   = 1'b0;
        frame_c     = '{stop: STOP_BIT, data: hold_reg_q, start: START_BIT};

        if (bus.tx_valid && !hold_full_q) begin
            hold_reg_d  = bus.tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d     = frame_c;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // Registered pulse lands on the final clock of the stop bit.
                if (pre_end_c && bit_cnt_q == last_bit) tx_done_d = 1'b1;
                if (bit_end_c) begin
                    if (bit_cnt_q != last_bit) begin
                        shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (hold_full_q) begin
                        shift_d     = frame_c;
                        hold_full_d = 1'b0;
                        bit_cnt_d   = '0;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_reg_q  <= '0;
            shift_q     <= '1;
            bit_cnt_q   <= '0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_reg_q  <= hold_reg_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // Shift register idles at all ones, so its LSB is the glitch-free line.
    assign bus.TxD      = shift_q[0];
    assign bus.tx_ready = ~hold_full_q;
    assign bus.tx_busy  = (state_q == SEND);
    assign bus.tx_done  = tx_done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: driver predicts frame timing, monitor checks the line.
module tb_uart_transmitter;

    localparam int DIV        = 50;
    localparam int FRAME_CLKS = 10 * DIV;

    typedef struct {
        logic [7:0] data;
        int         start;
        int         cut;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_start = -10000;
    exp_t sb_q[$];
    bit   mon_busy = 1'b0;
    bit   gap_bad = 1'b0;
    bit   gap_seen = 1'b0;

    uart_if bus();

    uart_transmitter #(.clk_freq(50_000_000), .baud_rate(1_000_000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Line level for frame bit b: start low, data LSB first, stop high.
    function automatic logic exp_line(input logic [7:0] d, input int b);
        logic [7:0] v;
        v = d;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return v[b-1];
    endfunction

    // Monitor: one negedge sample per clock, compared against the queued frame.
    initial begin : monitor
        exp_t cur;
        int   i, b, nframe;
        bit   bit_bad, busy_bad, done_bad;
        logic bit_act;
        nframe = 0; bit_bad = 0; busy_bad = 0; done_bad = 0; bit_act = 1'b0;
        cur = '{8'h00, 0, 0};
        forever begin
            @(negedge clk);
            if (!mon_busy && sb_q.size() > 0 && sb_q[0].start <= cyc) begin
                cur = sb_q.pop_front();
                if (gap_seen) chk("idle_line", !gap_bad, int'(gap_bad), 0);
                gap_seen = 0; gap_bad = 0;
                chk($sformatf("frame%0d_start", nframe), cur.start == cyc, cyc, cur.start);
                cur.start = cyc;
                mon_busy = 1; bit_bad = 0; busy_bad = 0; done_bad = 0;
            end
            if (mon_busy) begin
                i = cyc - cur.start;
                b = i / DIV;
                if (bus.TxD !== exp_line(cur.data, b)) begin
                    if (!bit_bad) bit_act = bus.TxD;
                    bit_bad = 1;
                end
                if (bus.tx_busy !== 1'b1) busy_bad = 1;
                if (bus.tx_done !== 1'(i == FRAME_CLKS - 1)) done_bad = 1;
                if ((i % DIV) == DIV - 1 || i == cur.cut - 1) begin
                    chk($sformatf("frame%0d_bit%0d_txd", nframe, b), !bit_bad,
                        int'(bit_bad ? bit_act : exp_line(cur.data, b)), int'(exp_line(cur.data, b)));
                    bit_bad = 0;
                end
                if (i == cur.cut - 1) begin
                    chk($sformatf("frame%0d_busy", nframe), !busy_bad, int'(busy_bad), 0);
                    chk($sformatf("frame%0d_done_pulse", nframe), !done_bad, int'(done_bad), 0);
                    nframe++;
                    mon_busy = 0;
                end
            end else begin
                gap_seen = 1;
                if (bus.TxD !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) gap_bad = 1;
            end
        end
    end

    // Offer a byte (valid stays high until accepted); predicts accept edge and frame start.
    task automatic send(input logic [7:0] d, input int cut);
        int e0, acc, waitc, exp_acc;
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        e0 = cyc + 1;
        waitc = 0;
        while (bus.tx_ready !== 1'b1 && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        if (bus.tx_ready !== 1'b1) begin
            chk("accept_timeout", 1'b0, waitc, 2000);
            bus.tx_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        exp_acc = imax(e0, last_start + 1);
        chk("accept_edge", acc == exp_acc, acc, exp_acc);
        last_start = imax(acc + 1, last_start + FRAME_CLKS);
        sb_q.push_back('{d, last_start, cut});
        @(negedge clk);
        chk("ready_low_after_accept", bus.tx_ready === 1'b0, int'(bus.tx_ready), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() > 0 || mon_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size() == 0 && !mon_busy, sb_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : driver
        int s, gap;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd",   bus.TxD === 1'b1,      int'(bus.TxD), 1);
        chk("rst_ready", bus.tx_ready === 1'b1, int'(bus.tx_ready), 1);
        chk("rst_busy",  bus.tx_busy === 1'b0,  int'(bus.tx_busy), 0);
        chk("rst_done",  bus.tx_done === 1'b0,  int'(bus.tx_done), 0);
        reset = 1'b0;
        repeat (20) begin
            bus.tx_data = 8'($urandom);
            @(negedge clk);
        end
        chk("idle_after_reset", bus.TxD === 1'b1 && bus.tx_ready === 1'b1, int'(bus.TxD), 1);

        // Single byte, then a pair queued mid-frame
        send(8'hA5, FRAME_CLKS);
        bus.tx_valid = 1'b0;
        drain();
        send(8'h00, FRAME_CLKS);
        bus.tx_valid = 1'b0;
        repeat (100) @(negedge clk);
        send(8'hFF, FRAME_CLKS);
        bus.tx_valid = 1'b0;
        drain();

        // Valid held high across three bytes
        send(8'h11, FRAME_CLKS);
        send(8'h22, FRAME_CLKS);
        send(8'h33, FRAME_CLKS);
        bus.tx_valid = 1'b0;
        drain();

        // Reset in the middle of data bit 4
        send(8'h3C, 276);
        bus.tx_valid = 1'b0;
        s = last_start;
        while (cyc < s + 275) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midframe_rst_txd",   bus.TxD === 1'b1,      int'(bus.TxD), 1);
        chk("midframe_rst_busy",  bus.tx_busy === 1'b0,  int'(bus.tx_busy), 0);
        chk("midframe_rst_ready", bus.tx_ready === 1'b1, int'(bus.tx_ready), 1);
        chk("midframe_rst_done",  bus.tx_done === 1'b0,  int'(bus.tx_done), 0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        last_start = -10000;
        repeat (10) @(negedge clk);
        send(8'h3C, FRAME_CLKS);
        bus.tx_valid = 1'b0;
        drain();

        // Random bytes with random idle gaps and garbage data while not valid
        repeat (40) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.tx_valid = 1'b0;
                gap = int'($urandom_range(1, 700));
                repeat (gap) begin
                    bus.tx_data = 8'($urandom);
                    @(negedge clk);
                end
            end
            send(8'($urandom), FRAME_CLKS);
        end
        bus.tx_valid = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        if (gap_seen) chk("final_idle_line", !gap_bad, int'(gap_bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
